// File: rtl/mem_bridge.sv
// mem_bridge: memory access stage between the multicycle control unit and a
// ready/valid memory port. Issues one bus transaction per accepted request,
// formats store byte lanes, extends load data, and holds the instruction
// register, old-PC latch and load data register.
//
// Optional feature macro: MISALIGN_TRAP_EN (misaligned requests are trapped
// instead of being issued with the low address bits dropped).
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req                     start an access (sampled only when idle)
//   AdrSrc                  0: address = pc, 1: address = result
//   IRWrite / MemWrite      access kind: fetch / store (else load)
//   funct3                  load/store size and signedness
//   pc, result, wdata       fetch address, data address, store data
//   busy, done              access in progress, one-cycle completion pulse
//   instr, old_pc, data     instruction reg, last fetch address, load data
//   bus_err, misalign       sticky timeout flag, misaligned-access pulse
//   m_valid, m_we, m_addr,
//   m_be, m_wdata           bus request channel
//   m_ready                 request accepted
//   m_rvalid, m_rdata       read response channel
module mem_bridge #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req,
   input  logic            AdrSrc,
   input  logic            IRWrite,
   input  logic            MemWrite,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] old_pc,
   output logic [XLEN-1:0] data,
   output logic            bus_err,
   output logic            misalign,
   output logic            m_valid,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [3:0]      m_be,
   output logic [XLEN-1:0] m_wdata,
   input  logic            m_ready,
   input  logic            m_rvalid,
   input  logic [XLEN-1:0] m_rdata
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [XLEN-1:0]  NOP      = XLEN'(32'h0000_0013);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fin_q, fin_d;
   logic              fin_err_q, fin_err_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;

   logic              busy_d, done_d, bus_err_d, misalign_d;
   logic [XLEN-1:0]   instr_d, old_pc_d, data_d;
   logic              m_valid_d, m_we_d;
   logic [XLEN-1:0]   m_addr_d, m_wdata_d;
   logic [3:0]        m_be_d;

   logic [XLEN-1:0]   sel_addr;
   kind_t             req_kind;
   logic [3:0]        req_be;
   logic [XLEN-1:0]   req_wdata;
   logic              trap;

   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_ext;

   // Request decode: address select, access kind, store lane formatting
   always_comb begin : req_format
      sel_addr = AdrSrc ? result : pc;
      if (IRWrite)       req_kind = K_FETCH;
      else if (MemWrite) req_kind = K_STORE;
      else               req_kind = K_LOAD;
      req_be    = 4'b1111;
      req_wdata = wdata;
      if (req_kind == K_STORE) begin
         case (funct3[1:0])
            2'b00: begin
               req_be    = 4'b0001 << sel_addr[1:0];
               req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               req_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
               req_wdata = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   logic [1:0] req_size;

   // Fetches are always word-sized; funct3 sizes 10/11 are treated as word
   always_comb begin : misalign_detect
      req_size = (req_kind == K_FETCH) ? 2'b10 : funct3[1:0];
      case (req_size)
         2'b00:   trap = 1'b0;
         2'b01:   trap = sel_addr[0];
         default: trap = |sel_addr[1:0];
      endcase
   end
`else
   assign trap = 1'b0;
`endif

   // Load lane select and extension from the latched address and funct3
   always_comb begin : load_extend
      case (addr_q[1:0])
         2'b00:   ld_byte = rdata_q[7:0];
         2'b01:   ld_byte = rdata_q[15:8];
         2'b10:   ld_byte = rdata_q[23:16];
         default: ld_byte = rdata_q[31:24];
      endcase
      ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (f3_q[1:0])
         2'b00:   ld_ext = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_ext = rdata_q;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin : fsm_next
      state_d    = state_q;
      kind_d     = kind_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      fin_d      = 1'b0;
      fin_err_d  = 1'b0;
      rdata_d    = rdata_q;
      busy_d     = busy;
      done_d     = 1'b0;
      misalign_d = 1'b0;
      bus_err_d  = bus_err;
      instr_d    = instr;
      old_pc_d   = old_pc;
      data_d     = data;
      m_valid_d  = m_valid;
      m_we_d     = m_we;
      m_addr_d   = m_addr;
      m_be_d     = m_be;
      m_wdata_d  = m_wdata;

      // Completion is published one cycle after the FSM returns to idle;
      // kind/addr/f3 still describe the finished access at this edge.
      if (fin_q) begin
         done_d = 1'b1;
         if (fin_err_q) begin
            bus_err_d = 1'b1;
         end else if (kind_q == K_FETCH) begin
            instr_d  = rdata_q;
            old_pc_d = addr_q;
         end else if (kind_q == K_LOAD) begin
            data_d = ld_ext;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (trap) begin
                  done_d     = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  state_d   = S_REQ;
                  kind_d    = req_kind;
                  f3_d      = funct3;
                  addr_d    = sel_addr;
                  cnt_d     = '0;
                  busy_d    = 1'b1;
                  m_valid_d = 1'b1;
                  m_we_d    = (req_kind == K_STORE);
                  m_addr_d  = {sel_addr[XLEN-1:2], 2'b00};
                  m_be_d    = req_be;
                  m_wdata_d = req_wdata;
               end
            end
         end
         S_REQ: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_we_d    = 1'b0;
               cnt_d     = cnt_q + CNT_W'(1);
               if (kind_q == K_STORE) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  fin_d   = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (cnt_q >= CNT_LAST) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               m_valid_d = 1'b0;
               m_we_d    = 1'b0;
               fin_d     = 1'b1;
               fin_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (m_rvalid) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               fin_d   = 1'b1;
               rdata_d = m_rdata;
            end else if (cnt_q >= CNT_LAST) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               fin_d     = 1'b1;
               fin_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            m_valid_d = 1'b0;
            m_we_d    = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin : regs
      if (!reset_n) begin
         state_q   <= S_IDLE;
         kind_q    <= K_FETCH;
         f3_q      <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         fin_q     <= 1'b0;
         fin_err_q <= 1'b0;
         rdata_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
         instr     <= NOP;
         old_pc    <= '0;
         data      <= '0;
         m_valid   <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_be      <= '0;
         m_wdata   <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         f3_q      <= f3_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         fin_q     <= fin_d;
         fin_err_q <= fin_err_d;
         rdata_q   <= rdata_d;
         busy      <= busy_d;
         done      <= done_d;
         misalign  <= misalign_d;
         bus_err   <= bus_err_d;
         instr     <= instr_d;
         old_pc    <= old_pc_d;
         data      <= data_d;
         m_valid   <= m_valid_d;
         m_we      <= m_we_d;
         m_addr    <= m_addr_d;
         m_be      <= m_be_d;
         m_wdata   <= m_wdata_d;
      end
   end

endmodule
